// File: rtl/alu_pkg_hdl.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states,
// default widths and a zero-extension helper.
package alu_pkg_hdl;

  localparam int DEF_OP_WIDTH     = 8;
  localparam int DEF_RESULT_WIDTH = 2 * DEF_OP_WIDTH;

  typedef enum logic [2:0] {
    NO_OP    = 3'b000,
    ADD_OP   = 3'b001,
    AND_OP   = 3'b010,
    XOR_OP   = 3'b011,
    MUL_OP   = 3'b100,
    RESET_OP = 3'b111
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  // Takes W+1 bits so the add carry fits; and/xor pass a leading zero.
  function automatic logic [DEF_RESULT_WIDTH-1:0] zext(input logic [DEF_OP_WIDTH:0] v);
    return {{(DEF_RESULT_WIDTH-DEF_OP_WIDTH-1){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// W cycles per product. Owns the bit counter and the accumulator.
module alu_mul_seq
  import alu_pkg_hdl::*;
#(
  parameter int W = DEF_OP_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           last,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  count;

  // product is the accumulator value after this cycle's step, so the core
  // can register it on the same edge that retires the final bit.
  assign product = mplier[0] ? (acc + mcand) : acc;
  assign busy    = (count != '0);
  assign last    = (count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= CW'(W);
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_core.sv
// Sequential ALU top: valid/ready accept, single-cycle add/and/xor,
// multi-cycle multiply via alu_mul_seq, registered done pulse and result.
module alu_core
  import alu_pkg_hdl::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid,
  output logic                    ready,
  input  logic [2:0]              alu_op,
  input  logic [DEF_OP_WIDTH-1:0] a,
  input  logic [DEF_OP_WIDTH-1:0] b,
  output logic                    done,
  output logic [DEF_RESULT_WIDTH-1:0] result
);

  localparam int ALU_IN_OP_WIDTH      = DEF_OP_WIDTH;
  localparam int ALU_OUT_RESULT_WIDTH = DEF_RESULT_WIDTH;

  alu_state_t state, next_state;

  logic                            accept;
  logic                            ready_d;
  logic                            done_d;
  logic [ALU_OUT_RESULT_WIDTH-1:0] result_d;
  logic                            mul_start;
  logic                            mul_busy;
  logic                            mul_last;
  logic [ALU_OUT_RESULT_WIDTH-1:0] mul_product;

  assign accept = valid && ready;

  alu_mul_seq #(.W(ALU_IN_OP_WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state  <= next_state;
      ready  <= ready_d;
      done   <= done_d;
      result <= result_d;
    end
  end

  // ready is registered, so it comes up one edge after reset release and
  // drops on the same edge that accepts a multiply.
  always_comb begin
    next_state = state;
    ready_d    = 1'b1;
    done_d     = 1'b0;
    result_d   = result;
    mul_start  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (alu_op_t'(alu_op))
            ADD_OP: begin
              result_d = zext({1'b0, a} + {1'b0, b});
              done_d   = 1'b1;
            end
            AND_OP: begin
              result_d = zext({1'b0, a & b});
              done_d   = 1'b1;
            end
            XOR_OP: begin
              result_d = zext({1'b0, a ^ b});
              done_d   = 1'b1;
            end
            MUL_OP: begin
              mul_start  = 1'b1;
              ready_d    = 1'b0;
              next_state = MUL;
            end
            RESET_OP: result_d = '0;
            default: ;
          endcase
        end
      end
      MUL: begin
        ready_d = 1'b0;
        if (mul_last) begin
          result_d   = mul_product;
          done_d     = 1'b1;
          ready_d    = 1'b1;
          next_state = IDLE;
        end else if (!mul_busy) begin
          ready_d    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_core;
  import alu_pkg_hdl::*;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [2:0]  alu_op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        done;
  logic [15:0] result;

  logic [15:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  alu_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (valid),
    .ready  (ready),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; holds the request until it is accepted, returns at
  // the negedge right after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                               input logic has_done, input logic [15:0] exp_val);
    int waited = 0;
    valid  = 1'b1;
    alu_op = op;
    a      = x;
    b      = y;
    while (!ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) checkOutput("accept_timeout", 16'(waited), 16'd0);
    if (has_done) exp_q.push_back(exp_val);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic countStall(input int expected);
    int n = 0;
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mul_stall_cycles", 16'(n), 16'(expected));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) checkOutput("unexpected_done", 16'(done), 16'd0);
        else checkOutput("result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    alu_op = 3'b000;
    a      = 8'h00;
    b      = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 16'(ready), 16'd0);
    checkOutput("reset_done", 16'(done), 16'd0);
    checkOutput("reset_result", result, 16'h0000);

    rst_n = 1'b1;
    #1 checkOutput("ready_before_first_edge", 16'(ready), 16'd0);
    @(negedge clk);
    checkOutput("ready_after_first_edge", 16'(ready), 16'd1);

    applyStimulus(ADD_OP, 8'hFF, 8'h01, 1'b1, 16'h0100);
    applyStimulus(AND_OP, 8'hF0, 8'h3C, 1'b1, 16'h0030);
    applyStimulus(XOR_OP, 8'hAA, 8'hFF, 1'b1, 16'h0055);
    repeat (2) @(negedge clk);

    applyStimulus(MUL_OP, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
    countStall(8);
    @(negedge clk);
    applyStimulus(MUL_OP, 8'h02, 8'h03, 1'b1, 16'h0006);
    applyStimulus(ADD_OP, 8'h01, 8'h02, 1'b1, 16'h0003);
    repeat (2) @(negedge clk);

    applyStimulus(ADD_OP, 8'h05, 8'h03, 1'b1, 16'h0008);
    checkOutput("result_after_add", result, 16'h0008);
    applyStimulus(NO_OP, 8'h11, 8'h22, 1'b0, 16'h0000);
    applyStimulus(3'b101, 8'h33, 8'h44, 1'b0, 16'h0000);
    checkOutput("result_held_noop", result, 16'h0008);
    applyStimulus(RESET_OP, 8'h00, 8'h00, 1'b0, 16'h0000);
    checkOutput("result_after_reset_op", result, 16'h0000);
    applyStimulus(NO_OP, 8'h00, 8'h00, 1'b0, 16'h0000);
    applyStimulus(3'b110, 8'h55, 8'h66, 1'b0, 16'h0000);
    checkOutput("result_held_after_reset_op", result, 16'h0000);

    applyStimulus(XOR_OP, 8'h0F, 8'hF0, 1'b1, 16'h00FF);
    applyStimulus(MUL_OP, 8'h12, 8'h34, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midmul_reset_ready", 16'(ready), 16'd0);
    checkOutput("midmul_reset_done", 16'(done), 16'd0);
    checkOutput("midmul_reset_result", result, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("result_after_midmul_reset", result, 16'h0000);
    applyStimulus(MUL_OP, 8'h12, 8'h34, 1'b1, 16'h03A8);
    countStall(8);
    @(negedge clk);

    applyStimulus(MUL_OP, 8'h00, 8'hFF, 1'b1, 16'h0000);
    countStall(8);
    @(negedge clk);
    applyStimulus(ADD_OP, 8'h00, 8'h00, 1'b1, 16'h0000);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Sequential ALU datapath feeding the ALU output interface. Accepts one operation at a time on a valid/ready input handshake and computes add, and, xor, or multiply. Multiply is iterative shift-add, so the block stalls upstream while it runs. Each result is presented as a one-cycle `done` pulse with a held `result` bus.

## Interface
- `ALU_IN_OP_WIDTH`, 8, operand width of `a` and `b`.
- `ALU_OUT_RESULT_WIDTH`, 16, result width; must equal 2*`ALU_IN_OP_WIDTH`.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid`  in  1  operation request present.
- `ready`  out  1  block can accept an operation this cycle.
- `alu_op`  in  3  operation code (`alu_op_t`).
- `a`, `b`  in  `ALU_IN_OP_WIDTH`  operands.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  `ALU_OUT_RESULT_WIDTH`  last computed result, held between pulses.

## Operation
- Opcodes:
  - no_op=3'b000
  - add_op=3'b001
  - and_op=3'b010
  - xor_op=3'b011
  - mul_op=3'b100
  - reset_op=3'b111
- 3'b101 and 3'b110 are treated as no_op.
- Accept: edge where `valid && ready`. Operands and opcode are captured at that edge; later input changes are ignored.
- States: IDLE, MUL.
- IDLE:
  - `ready`=1.
  - add/and/xor: result computed and registered at the accept edge; `done`=1 for the following cycle; stay IDLE.
  - mul_op: load multiplicand/multiplier, clear accumulator, set counter to `ALU_IN_OP_WIDTH`, go to MUL.
  - reset_op: `result` cleared to 0, no `done`, stay IDLE.
  - no_op: accepted, no effect, no `done`.
- MUL:
  - `ready`=0.
  - Each edge: if the multiplier LSB is set, add the shifted multiplicand to the accumulator. Shift multiplicand left and multiplier right; decrement counter.
  - On the edge that decrements the counter to 0: register the accumulator to `result`, assert `done` for the next cycle, return to IDLE.
- Arithmetic, with W=`ALU_IN_OP_WIDTH`:
  - add: zero-extended W+1-bit sum, upper bits 0.
  - and/xor: bitwise on W bits, zero-extended.
  - mul: unsigned 2W-bit product, no overflow possible.
- `result` changes only on a `done`-producing edge or on reset_op. Otherwise it holds.

## Timing
- Reset (async assert): `ready`=0, `done`=0, `result`=0, state IDLE, counter 0, multiplier registers 0.
- `ready` is registered. It rises at the first `clk` edge after `rst_n` deasserts, so no accept is possible in that first cycle.
- add/and/xor: latency 1, meaning `done` is high in the cycle after the accept edge. Throughput is one operation per cycle; back-to-back accepts give back-to-back `done` pulses.
- mul:
  - Accept at edge N; `ready` is low from N to N+W.
  - `done` is high in the cycle after edge N+W; latency is W cycles.
  - `ready` is high in that same cycle, so a new accept is possible at edge N+W+1.
- `done` never stays high for more than one cycle unless another single-cycle op was accepted at the previous edge.
- `valid` while `ready`=0 is ignored (not queued). Upstream must hold the request until an accept edge.
- Reset mid-MUL: the operation is discarded, no `done`, and all outputs go to reset values immediately.
- Reset asserted in the same cycle as `done`: `done` drops asynchronously and the pulse is lost. This is acceptable.

## Structure
- Shared package `alu_pkg_hdl`:
  - `alu_op_t` enum with the encodings above.
  - Default width constants.
  - Helper function for zero-extension of W-bit values to result width.
- Sub-module `alu_mul_seq`: the shift-add multiplier.
  - Ports: `start`, operands, `busy`, `last`, `product`.
  - Owns the counter and the accumulator.
- `alu_core` owns the FSM, the handshake, the single-cycle ops and the `result`/`done` registers.

## Test plan
- Reset release: `rst_n` low→high. `ready`=0 until the first edge, then 1; `done`=0, `result`=16'h0000.
- Back-to-back single ops: add 8'hFF+8'h01, then and 8'hF0&8'h3C, then xor 8'hAA^8'hFF on three consecutive accepts. Expect `done` high 3 consecutive cycles with `result` 16'h0100, 16'h0030, 16'h0055.
- Multiply: mul 8'hFF*8'hFF. Expect `ready` low for 8 cycles, then `done` with 16'hFE01. A request held during the stall is accepted only after `ready` returns.
- reset_op after add 8'h05+8'h03 (`result` 16'h0008): expect `result` 16'h0000 at the next edge and no `done`. A following no_op and opcode 3'b101 also produce no `done` and no `result` change.
- Async reset at cycle 4 of mul 8'h12*8'h34: outputs reset immediately, no `done` ever appears. A fresh mul 8'h12*8'h34 after reset yields 16'h03A8.
- Boundaries: mul 8'h00*8'hFF gives 16'h0000 after full 8-cycle latency; add 8'h00+8'h00 still pulses `done` with 16'h0000.
